// File: rtl/overlay_pkg.sv
// Shared types and constants for the overlay transform pipe: scale thresholds,
// scale codes, FSM states and the fixed-point widths used by the datapath.
package overlay_pkg;

    localparam int COORD_W = 11;
    localparam int VEC_W   = 12;
    localparam int DIST_W  = 23;

    localparam logic [DIST_W-1:0] THR_X4   = DIST_W'(230400);
    localparam logic [DIST_W-1:0] THR_X2   = DIST_W'(102400);
    localparam logic [DIST_W-1:0] THR_X1   = DIST_W'(36864);
    localparam logic [DIST_W-1:0] THR_HALF = DIST_W'(100);

    typedef enum logic [2:0] {
        SC_Q25  = 3'd0,
        SC_HALF = 3'd1,
        SC_X1   = 3'd2,
        SC_X2   = 3'd3,
        SC_X4   = 3'd4
    } scale_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_DIST   = 3'd2,
        S_TRIG   = 3'd3,
        S_COMMIT = 3'd4
    } state_e;

    function automatic scale_e scale_from_dist(input logic [DIST_W-1:0] d2);
        scale_e code;
        if (d2 >= THR_X4)        code = SC_X4;
        else if (d2 >= THR_X2)   code = SC_X2;
        else if (d2 >= THR_X1)   code = SC_X1;
        else if (d2 >= THR_HALF) code = SC_HALF;
        else                     code = SC_Q25;
        return code;
    endfunction

endpackage

// File: rtl/overlay_xform_pipe_pix.sv
// Three-stage pixel pipe: offset, rotate (four truncated products), then
// scale, bounds test and ROM address generation. One pixel per cycle.
module overlay_pix_stage
    import overlay_pkg::*;
#(
    parameter int P_IMG_W  = 200,
    parameter int P_IMG_H  = 140,
    parameter int P_ADDR_W = 15,
    parameter int P_FRAC   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pix_valid_in,
    input  logic [COORD_W-1:0]        vga_x,
    input  logic [COORD_W-1:0]        vga_y,
    input  logic [COORD_W-1:0]        off_x,
    input  logic [COORD_W-1:0]        off_y,
    input  logic signed [P_FRAC+1:0]  cos_v,
    input  logic signed [P_FRAC+1:0]  sin_v,
    input  logic [2:0]                scale,
    input  logic                      enable,
    output logic                      pix_valid_out,
    output logic                      draw_image,
    output logic [P_ADDR_W-1:0]       rom_addr
);

    localparam int TRIG_W = P_FRAC + 2;
    // Wide enough for the full product plus a two-bit left shift and sign.
    localparam int UW = TRIG_W + VEC_W + 4;

    logic                    v1, v2;
    logic signed [VEC_W-1:0] ox_q, oy_q;
    logic signed [UW-1:0]    ox_e, oy_e, cos_e, sin_e;
    logic signed [UW-1:0]    cx_q, sy_q, cy_q, sx_q;
    logic signed [UW-1:0]    u_raw, v_raw, u_sc, v_sc;
    logic [2:0]              rsh, lsh;
    logic                    in_box, hit;
    logic [P_ADDR_W-1:0]     addr_nxt;

    assign ox_e  = {{(UW-VEC_W){ox_q[VEC_W-1]}}, ox_q};
    assign oy_e  = {{(UW-VEC_W){oy_q[VEC_W-1]}}, oy_q};
    assign cos_e = {{(UW-TRIG_W){cos_v[TRIG_W-1]}}, cos_v};
    assign sin_e = {{(UW-TRIG_W){sin_v[TRIG_W-1]}}, sin_v};

    always_comb begin
        rsh   = scale - 3'd2;
        lsh   = 3'd2 - scale;
        u_raw = cx_q - sy_q;
        v_raw = sx_q + cy_q;
        u_sc  = (scale > 3'd2) ? (u_raw >>> rsh) : (u_raw <<< lsh);
        v_sc  = (scale > 3'd2) ? (v_raw >>> rsh) : (v_raw <<< lsh);
        in_box = !u_sc[UW-1] && (u_sc < UW'(P_IMG_W)) &&
                 !v_sc[UW-1] && (v_sc < UW'(P_IMG_H));
        hit      = v2 && in_box && enable;
        addr_nxt = u_sc[P_ADDR_W-1:0] + P_ADDR_W'(P_IMG_W) * v_sc[P_ADDR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            ox_q <= '0;
            oy_q <= '0;
            cx_q <= '0;
            sy_q <= '0;
            cy_q <= '0;
            sx_q <= '0;
            pix_valid_out <= 1'b0;
            draw_image    <= 1'b0;
            rom_addr      <= '0;
        end else begin
            v1   <= pix_valid_in;
            ox_q <= $signed({1'b0, vga_x}) - $signed({1'b0, off_x});
            oy_q <= $signed({1'b0, vga_y}) - $signed({1'b0, off_y});
            v2   <= v1;
            cx_q <= (cos_e * ox_e) >>> P_FRAC;
            sy_q <= (sin_e * oy_e) >>> P_FRAC;
            cy_q <= (cos_e * oy_e) >>> P_FRAC;
            sx_q <= (sin_e * ox_e) >>> P_FRAC;
            pix_valid_out <= v2;
            draw_image    <= hit;
            rom_addr      <= hit ? addr_nxt : '0;
        end
    end

endmodule

// File: rtl/overlay_xform_pipe.sv
// Per-frame parameter engine (corner latch, distance, trig handshake, scale
// hysteresis, lost timeout) feeding a shadowed parameter set to the pixel pipe.
module overlay_xform_pipe
    import overlay_pkg::*;
#(
    parameter int P_IMG_W  = 200,
    parameter int P_IMG_H  = 140,
    parameter int P_ADDR_W = 15,
    parameter int P_FRAC   = 8,
    parameter int P_HYST   = 2,
    parameter int P_LOST   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic                     corners_valid,
    input  logic [COORD_W-1:0]       tl_x,
    input  logic [COORD_W-1:0]       tl_y,
    input  logic [COORD_W-1:0]       tr_x,
    input  logic [COORD_W-1:0]       tr_y,
    input  logic [COORD_W-1:0]       bl_x,
    input  logic [COORD_W-1:0]       bl_y,
    input  logic [COORD_W-1:0]       br_x,
    input  logic [COORD_W-1:0]       br_y,
    output logic                     trig_req,
    output logic signed [VEC_W-1:0]  trig_dx,
    output logic signed [VEC_W-1:0]  trig_dy,
    input  logic                     trig_ack,
    input  logic signed [P_FRAC+1:0] cos_in,
    input  logic signed [P_FRAC+1:0] sin_in,
    input  logic                     pix_valid_in,
    input  logic [COORD_W-1:0]       vga_x,
    input  logic [COORD_W-1:0]       vga_y,
    output logic                     pix_valid_out,
    output logic                     draw_image,
    output logic [P_ADDR_W-1:0]      rom_addr,
    output logic [2:0]               scale,
    output logic                     params_ready,
    output logic                     lost,
    output logic [2:0]               fsm_state
);

    localparam int TRIG_W = P_FRAC + 2;
    localparam int MISS_W = $clog2(P_LOST + 1);
    localparam int HYST_W = $clog2(P_HYST + 1);
    localparam logic signed [TRIG_W-1:0] ONE_Q = TRIG_W'(1 << P_FRAC);

    // Handshake: trig_req rises in TRIG and holds with trig_dx/trig_dy stable;
    // the transfer completes on the first cycle trig_ack is seen while trig_req=1.
    state_e state, state_nxt;

    logic [COORD_W-1:0]       start_x, start_y, end_x, end_y;
    logic [COORD_W:0]         mid_l, mid_r;
    logic signed [VEC_W-1:0]  dx_q, dy_q;
    logic signed [DIST_W-1:0] dx_e, dy_e, dx_sq, dy_sq;
    logic [DIST_W-1:0]        dist2_q;
    logic signed [TRIG_W-1:0] cos_q, sin_q, sh_cos, sh_sin;
    logic [COORD_W-1:0]       sh_off_x, sh_off_y;
    scale_e                   scale_q, cand_q, cand;
    logic [HYST_W-1:0]        cand_cnt, cand_cnt_nxt;
    logic [MISS_W-1:0]        miss_cnt;
    logic                     params_ready_q, lost_q;
    logic                     latch_go, miss_go;
    logic                     unused_corner_x;

    // Left/right edges come from the top corners; bottom x is not part of the geometry.
    assign unused_corner_x = ^{bl_x, br_x};

    assign latch_go = (state == S_IDLE) && frame_start && corners_valid;
    assign miss_go  = (state == S_IDLE) && frame_start && !corners_valid;
    assign mid_l    = {1'b0, tl_y} + {1'b0, bl_y};
    assign mid_r    = {1'b0, tr_y} + {1'b0, br_y};
    assign dx_e     = {{(DIST_W-VEC_W){dx_q[VEC_W-1]}}, dx_q};
    assign dy_e     = {{(DIST_W-VEC_W){dy_q[VEC_W-1]}}, dy_q};
    assign dx_sq    = dx_e * dx_e;
    assign dy_sq    = dy_e * dy_e;
    assign cand     = scale_from_dist(dist2_q);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (latch_go) state_nxt = S_LATCH;
            S_LATCH:  state_nxt = S_DIST;
            S_DIST:   state_nxt = S_TRIG;
            S_TRIG:   if (trig_ack) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cand_cnt_nxt = HYST_W'(1);
        if (cand == cand_q)
            cand_cnt_nxt = (cand_cnt == HYST_W'(P_HYST)) ? cand_cnt : cand_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            start_x  <= '0;
            start_y  <= '0;
            end_x    <= '0;
            end_y    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            dist2_q  <= '0;
            cos_q    <= ONE_Q;
            sin_q    <= '0;
            sh_cos   <= ONE_Q;
            sh_sin   <= '0;
            sh_off_x <= '0;
            sh_off_y <= '0;
            scale_q  <= SC_X1;
            cand_q   <= SC_X1;
            cand_cnt <= '0;
            miss_cnt <= '0;
            lost_q   <= 1'b0;
            params_ready_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (latch_go) begin
                start_x  <= tl_x;
                start_y  <= mid_l[COORD_W:1];
                end_x    <= tr_x;
                end_y    <= mid_r[COORD_W:1];
                miss_cnt <= '0;
                lost_q   <= 1'b0;
            end else if (miss_go) begin
                if (miss_cnt != MISS_W'(P_LOST))
                    miss_cnt <= miss_cnt + 1'b1;
                if (32'(miss_cnt) + 1 >= P_LOST)
                    lost_q <= 1'b1;
            end
            if (state == S_LATCH) begin
                dx_q <= $signed({1'b0, end_x}) - $signed({1'b0, start_x});
                dy_q <= $signed({1'b0, end_y}) - $signed({1'b0, start_y});
            end
            if (state == S_DIST)
                dist2_q <= dx_sq + dy_sq;
            if (state == S_TRIG && trig_ack) begin
                cos_q <= cos_in;
                sin_q <= sin_in;
            end
            // Only COMMIT touches the shadow set, so a frame never sees a mix.
            if (state == S_COMMIT) begin
                sh_cos   <= cos_q;
                sh_sin   <= sin_q;
                sh_off_x <= start_x;
                sh_off_y <= start_y;
                params_ready_q <= 1'b1;
                cand_q   <= cand;
                cand_cnt <= cand_cnt_nxt;
                if (32'(cand_cnt_nxt) >= P_HYST)
                    scale_q <= cand;
            end
        end
    end

    assign trig_req     = (state == S_TRIG);
    assign trig_dx      = dx_q;
    assign trig_dy      = dy_q;
    assign scale        = scale_q;
    assign params_ready = params_ready_q;
    assign lost         = lost_q;
    assign fsm_state    = state;

    overlay_pix_stage #(
        .P_IMG_W  (P_IMG_W),
        .P_IMG_H  (P_IMG_H),
        .P_ADDR_W (P_ADDR_W),
        .P_FRAC   (P_FRAC)
    ) u_pix (
        .clk           (clk),
        .reset         (reset),
        .pix_valid_in  (pix_valid_in),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .off_x         (sh_off_x),
        .off_y         (sh_off_y),
        .cos_v         (sh_cos),
        .sin_v         (sh_sin),
        .scale         (scale_q),
        .enable        (params_ready_q && !lost_q),
        .pix_valid_out (pix_valid_out),
        .draw_image    (draw_image),
        .rom_addr      (rom_addr)
    );

endmodule
